maxpool_array: RTL and testbench

MAXPOOL_ARRAY -- requirements
Module: maxpool_array

---
 rtl/maxpool_pkg.sv | 11 +
 rtl/maxpool_lane.sv | 34 +++
 rtl/maxpool_array.sv | 103 ++++++++++
 tb/tb_maxpool_array.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared defaults and cfg_pool encodings for the max-pool array.
package maxpool_pkg;

  localparam int N_DEFAULT       = 32;
  localparam int LANES_DEFAULT   = 4;
  localparam int WIN_MAX_DEFAULT = 16;

  localparam logic POOL_PASS = 1'b0;
  localparam logic POOL_MAX  = 1'b1;

endpackage

// File: rtl/maxpool_lane.sv
// One pooling lane: an N-bit signed accumulator that either reloads with the
// incoming beat (first beat of a window) or keeps the signed maximum.
module maxpool_lane
  import maxpool_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic                first,
  input  logic signed [N-1:0] din,
  output logic signed [N-1:0] nxt
);

  logic signed [N-1:0] acc;

  // Ties keep the accumulator; nxt also feeds the output register on the final beat.
  always_comb begin
    nxt = (first || (din > acc)) ? din : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= nxt;
    end
  end

endmodule

// File: rtl/maxpool_array.sv
// LANES-wide streaming max-pool with per-window config latching and a
// registered output stage. Define MAXPOOL_RELU_EN to clamp negative results to 0.
module maxpool_array
  import maxpool_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int LANES   = LANES_DEFAULT,
  parameter int WIN_MAX = WIN_MAX_DEFAULT,
  parameter int CW      = $clog2(WIN_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cfg_pool,
  input  logic [CW-1:0]      cfg_win,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_data,
  output logic               busy
);

  logic [CW-1:0]      count;
  logic [CW-1:0]      win_len;
  logic [CW-1:0]      cfg_len;
  logic [CW-1:0]      cur_len;
  logic               accept;
  logic               first;
  logic               last;
  logic [LANES*N-1:0] nxt_all;
  logic [LANES*N-1:0] result;

  // Pass-through is simply a window of one beat.
  always_comb begin
    if (cfg_pool == POOL_PASS) begin
      cfg_len = CW'(1);
    end else if (cfg_win == '0) begin
      cfg_len = CW'(1);
    end else if (cfg_win > CW'(WIN_MAX)) begin
      cfg_len = CW'(WIN_MAX);
    end else begin
      cfg_len = cfg_win;
    end
  end

  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign first    = (count == '0);
  assign cur_len  = first ? cfg_len : win_len;
  assign last     = accept && ((count + CW'(1)) == cur_len);
  assign busy     = (count != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    maxpool_lane #(.N(N)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (accept),
      .first (first),
      .din   (in_data[i*N +: N]),
      .nxt   (nxt_all[i*N +: N])
    );
  end

  always_comb begin
    result = nxt_all;
`ifdef MAXPOOL_RELU_EN
    for (int i = 0; i < LANES; i++) begin
      if (nxt_all[i*N + N - 1]) begin
        result[i*N +: N] = '0;
      end
    end
`endif
  end

  // A completing window may reload the output on the same edge it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      win_len   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (accept) begin
        count <= last ? '0 : count + CW'(1);
        if (first) begin
          win_len <= cfg_len;
        end
      end
      if (last) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_array.sv
// Directed, table-driven bench for maxpool_array (default N=32, LANES=4, WIN_MAX=16).
module tb_maxpool_array;

  localparam int N     = 32;
  localparam int LANES = 4;
  localparam int CW    = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               cfg_pool = 1'b0;
  logic [CW-1:0]      cfg_win = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*N-1:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [LANES*N-1:0] out_data;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  maxpool_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cfg_pool  (cfg_pool),
    .cfg_win   (cfg_win),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               pool;
    logic [CW-1:0]      win;
    logic [LANES*N-1:0] din;
    logic               exp_valid;
    logic               exp_busy;
    logic [LANES*N-1:0] exp_data;
  } vec_t;

  function automatic logic [LANES*N-1:0] pk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [LANES*N-1:0] rs(input int a, input int b, input int c, input int d);
    return pk(relu(a), relu(b), relu(c), relu(d));
  endfunction

  function automatic logic [LANES*N-1:0] rep(input int x);
    return pk(x, x, x, x);
  endfunction

  function automatic vec_t mk(input logic p, input logic [CW-1:0] w, input logic [LANES*N-1:0] d,
                              input logic v, input logic b, input logic [LANES*N-1:0] e);
    vec_t r;
    r.pool = p; r.win = w; r.din = d; r.exp_valid = v; r.exp_busy = b; r.exp_data = e;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [LANES*N-1:0] act,
                              input logic [LANES*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock with the given inputs held; returns #1 after the rising edge.
  task automatic apply_stimulus(input logic p, input logic [CW-1:0] w, input logic [LANES*N-1:0] d,
                                input logic v, input logic r);
    cfg_pool  = p;
    cfg_win   = w;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // max, win=4
    tbl.push_back(mk(1, 4, pk(1, -1, 0, 100),    0, 1, '0));
    tbl.push_back(mk(1, 4, pk(-4, -1, 5, -100),  0, 1, '0));
    tbl.push_back(mk(1, 4, pk(9, -1, -3, 50),    0, 1, '0));
    tbl.push_back(mk(1, 4, pk(3, -1, 2, 99),     1, 0, rs(9, -1, 5, 100)));
    // all-negative win=3 with a mid-window config change that must be ignored
    tbl.push_back(mk(1, 3, pk(-7, -7, -7, -7),   0, 1, '0));
    tbl.push_back(mk(0, 1, pk(-2, -3, 6, -9),    0, 1, '0));
    tbl.push_back(mk(0, 1, pk(-5, -1, -8, -8),   1, 0, rs(-2, -1, 6, -7)));
    // win=0 acts as a single-beat window
    tbl.push_back(mk(1, 0, pk(42, -42, 0, 1),    1, 0, rs(42, -42, 0, 1)));
    // pass-through, back to back
    tbl.push_back(mk(0, 5, pk(5, -5, 0, 0),      1, 0, rs(5, -5, 0, 0)));
    tbl.push_back(mk(0, 5, pk(6, -6, 1, 2),      1, 0, rs(6, -6, 1, 2)));
    tbl.push_back(mk(0, 5, pk(7, -7, 2, 3),      1, 0, rs(7, -7, 2, 3)));

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_out_valid", {127'd0, out_valid}, '0);
    check_output("reset_out_data", out_data, '0);
    check_output("reset_busy", {127'd0, busy}, '0);
    check_output("reset_in_ready", {127'd0, in_ready}, 128'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].pool, tbl[i].win, tbl[i].din, 1'b1, 1'b1);
      check_output($sformatf("tbl%0d_out_valid", i), {127'd0, out_valid}, {127'd0, tbl[i].exp_valid});
      check_output($sformatf("tbl%0d_busy", i), {127'd0, busy}, {127'd0, tbl[i].exp_busy});
      check_output($sformatf("tbl%0d_in_ready", i), {127'd0, in_ready}, 128'd1);
      if (tbl[i].exp_valid)
        check_output($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_data);
    end
    apply_stimulus(1'b0, 5'd1, '0, 1'b0, 1'b1);
    check_output("idle_out_valid", {127'd0, out_valid}, '0);

    // win=20 clamps to 16 beats
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 5'd20, pk(i - 8, i, -i, 3), 1'b1, 1'b1);
      if (i == 14) check_output("clamp_no_early_out", {127'd0, out_valid}, '0);
    end
    check_output("clamp_out_valid", {127'd0, out_valid}, 128'd1);
    check_output("clamp_out_data", out_data, rs(7, 15, 0, 3));

    // back-pressure: output held, input stalled, then handshake plus same-edge reload
    apply_stimulus(1'b1, 5'd2, rep(3), 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd2, rep(4), 1'b1, 1'b1);
    check_output("stall_first_out", out_data, rep(4));
    cfg_pool = 1'b1; cfg_win = 5'd2; in_data = rep(10); in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check_output("stall_in_ready_low", {127'd0, in_ready}, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_output("stall_out_valid_held", {127'd0, out_valid}, 128'd1);
      check_output("stall_out_data_held", out_data, rep(4));
      check_output("stall_busy", {127'd0, busy}, '0);
    end
    apply_stimulus(1'b1, 5'd1, rep(10), 1'b1, 1'b1);
    check_output("reload_out_valid", {127'd0, out_valid}, 128'd1);
    check_output("reload_out_data", out_data, rep(10));
    apply_stimulus(1'b1, 5'd1, '0, 1'b0, 1'b1);
    check_output("reload_drain", {127'd0, out_valid}, '0);

    // clr after two beats discards the 8
    apply_stimulus(1'b1, 5'd4, rep(8), 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd4, rep(5), 1'b1, 1'b1);
    check_output("clr_busy_before", {127'd0, busy}, 128'd1);
    clr = 1'b1; in_data = rep(50); in_valid = 1'b1;
    #1;
    check_output("clr_in_ready_low", {127'd0, in_ready}, '0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_output("clr_busy_after", {127'd0, busy}, '0);
    apply_stimulus(1'b1, 5'd4, rep(1), 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd4, rep(2), 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd4, rep(3), 1'b1, 1'b1);
    check_output("clr_no_early_out", {127'd0, out_valid}, '0);
    apply_stimulus(1'b1, 5'd4, rep(0), 1'b1, 1'b1);
    check_output("clr_out_valid", {127'd0, out_valid}, 128'd1);
    check_output("clr_out_data", out_data, rep(3));
    // clr must not touch a pending output
    clr = 1'b1;
    apply_stimulus(1'b1, 5'd4, rep(77), 1'b1, 1'b0);
    clr = 1'b0;
    check_output("clr_pending_valid", {127'd0, out_valid}, 128'd1);
    check_output("clr_pending_data", out_data, rep(3));
    apply_stimulus(1'b1, 5'd4, '0, 1'b0, 1'b1);

    // asynchronous reset mid-window
    apply_stimulus(1'b1, 5'd4, rep(6), 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd4, rep(7), 1'b1, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid_busy", {127'd0, busy}, '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // asynchronous reset with a pending output
    apply_stimulus(1'b0, 5'd1, rep(9), 1'b1, 1'b0);
    in_valid = 1'b0;
    check_output("rst_pending_valid", {127'd0, out_valid}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_async_out_valid", {127'd0, out_valid}, '0);
    check_output("rst_async_out_data", out_data, '0);
    check_output("rst_async_busy", {127'd0, busy}, '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 5'd2, rep(-3), 1'b1, 1'b1);
    check_output("post_rst_busy", {127'd0, busy}, 128'd1);
    check_output("post_rst_no_out", {127'd0, out_valid}, '0);
    apply_stimulus(1'b1, 5'd2, rep(-1), 1'b1, 1'b1);
    check_output("post_rst_out_valid", {127'd0, out_valid}, 128'd1);
    check_output("post_rst_out_data", out_data, rs(-1, -1, -1, -1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
